// File: rtl/requant_pkg.sv
// Shared types and constants for the int32 -> int8 requantization block.
package requant_pkg;

   localparam logic signed [7:0] INT8_MAX  = 8'sh7F;
   localparam logic signed [7:0] INT8_MIN  = 8'sh80;
   // Channel field width carried in the output beat; covers up to 256 channels.
   localparam int                BEAT_CH_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   typedef struct packed {
      logic signed [7:0]      q;
      logic [BEAT_CH_W-1:0]   ch;
      logic                   last;
   } beat_t;

endpackage

// File: rtl/requant_core.sv
// Two-stage multiply / round / clamp datapath. The whole pipe moves only when
// advance is high, so a stalled output holds every stage in place.
module requant_core
   import requant_pkg::*;
#(
   parameter int CH_W  = 4,
   parameter int SHIFT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                advance,
   input  logic                in_vld,
   input  logic signed [31:0]  in_acc,
   input  logic signed [31:0]  in_scale,
   input  logic [CH_W-1:0]     in_ch,
   input  logic                in_last,
   output logic                vld_p1,
   output logic                out_valid,
   output beat_t               out_beat,
   output logic                out_sat
);

   localparam logic [63:0] HALF = 64'd1 << (SHIFT - 1);

   // Round half away from zero on the magnitude, then restore the sign.
   function automatic logic signed [63:0] round_hafz(input logic signed [63:0] prod);
      logic [63:0] mag;
      logic [63:0] r;
      mag = (prod < 0) ? -prod : prod;
      r   = (mag + HALF) >> SHIFT;
      return (prod < 0) ? -$signed(r) : $signed(r);
   endfunction

   function automatic logic is_sat(input logic signed [63:0] res);
      return (res > 64'(INT8_MAX)) || (res < 64'(INT8_MIN));
   endfunction

   function automatic logic signed [7:0] clamp_int8(input logic signed [63:0] res);
      if (res > 64'(INT8_MAX)) return INT8_MAX;
      if (res < 64'(INT8_MIN)) return INT8_MIN;
      return res[7:0];
   endfunction

   logic                vld_p1_q, vld_p1_d;
   logic signed [63:0]  prod_p1_q, prod_p1_d;
   logic [CH_W-1:0]     ch_p1_q, ch_p1_d;
   logic                last_p1_q, last_p1_d;
   logic                vld_p2_q, vld_p2_d;
   beat_t               beat_p2_q, beat_p2_d;
   logic                sat_p2_q, sat_p2_d;
   logic signed [63:0]  res_p1;

   // Stage 1: full-precision product of accumulator and channel scale.
   always_comb begin
      vld_p1_d  = vld_p1_q;
      prod_p1_d = prod_p1_q;
      ch_p1_d   = ch_p1_q;
      last_p1_d = last_p1_q;
      if (advance) begin
         vld_p1_d  = in_vld;
         prod_p1_d = 64'(in_acc) * 64'(in_scale);
         ch_p1_d   = in_ch;
         last_p1_d = in_last && in_vld;
      end
   end

   // Stage 1 valid is cleared by reset so in-flight beats are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) vld_p1_q <= 1'b0;
      else        vld_p1_q <= vld_p1_d;
   end

   // Stage 1 data carries no reset.
   always_ff @(posedge clk) begin
      prod_p1_q <= prod_p1_d;
      ch_p1_q   <= ch_p1_d;
      last_p1_q <= last_p1_d;
   end

   // Stage 2: round, clamp and flag saturation; data only loads with a valid beat.
   always_comb begin
      res_p1    = round_hafz(prod_p1_q);
      vld_p2_d  = vld_p2_q;
      beat_p2_d = beat_p2_q;
      sat_p2_d  = sat_p2_q;
      if (advance) begin
         vld_p2_d = vld_p1_q;
         if (vld_p1_q) begin
            beat_p2_d.q    = clamp_int8(res_p1);
            beat_p2_d.ch   = BEAT_CH_W'(ch_p1_q);
            beat_p2_d.last = last_p1_q;
            sat_p2_d       = is_sat(res_p1);
         end
      end
   end

   // Output register is fully cleared so the port reads zero out of reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p2_q  <= 1'b0;
         beat_p2_q <= '0;
         sat_p2_q  <= 1'b0;
      end else begin
         vld_p2_q  <= vld_p2_d;
         beat_p2_q <= beat_p2_d;
         sat_p2_q  <= sat_p2_d;
      end
   end

   assign vld_p1    = vld_p1_q;
   assign out_valid = vld_p2_q;
   assign out_beat  = beat_p2_q;
   assign out_sat   = sat_p2_q;

endmodule

// File: rtl/requant_ctrl.sv
// Frame sequencer for int32 -> int8 requantization: scale table, channel and
// pixel counting, frame FSM, and the two-stage requant datapath.
// Optional feature: define REQUANT_SATCNT_EN to add the sat_cnt output.
module requant_ctrl
   import requant_pkg::*;
#(
   parameter int  NUM_CH = 16,
   parameter int  SHIFT  = 16,
   parameter int  PIX_W  = 16,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_addr,
   input  logic signed [31:0]  cfg_scale,
   input  logic                start,
   input  logic [PIX_W-1:0]    num_pix,
   output logic                busy,
   output logic                done,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [31:0]  in_acc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [7:0]   out_q,
   output logic [CH_W-1:0]     out_ch,
   output logic                out_last
`ifdef REQUANT_SATCNT_EN
   ,output logic [15:0]        sat_cnt
`endif
);

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
   logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
   logic [PIX_W-1:0]    num_pix_q, num_pix_d;
   logic                zero_done_q, zero_done_d;
   logic signed [31:0]  scale_q [NUM_CH];

   logic                advance;
   logic                accept;
   logic                last_beat;
   logic                pipe_empty;
   logic                core_vld_p1;
   logic                core_sat;
   beat_t               core_beat;
   logic                unused_ok;

   assign advance    = !out_valid || out_ready;
   assign in_ready   = (state_q == RUN) && advance;
   assign accept     = in_valid && in_ready;
   assign last_beat  = (ch_idx_q == CH_W'(NUM_CH - 1)) && (pix_cnt_q == num_pix_q - PIX_W'(1));
   assign pipe_empty = !core_vld_p1 && !out_valid;

   // Scale table: writable only while idle, never reset.
   always_ff @(posedge clk) begin
      if (cfg_we && state_q == IDLE) scale_q[cfg_addr] <= cfg_scale;
   end

   // Frame FSM and beat sequencing counters.
   always_comb begin
      state_d     = state_q;
      ch_idx_d    = ch_idx_q;
      pix_cnt_d   = pix_cnt_q;
      num_pix_d   = num_pix_q;
      zero_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               num_pix_d = num_pix;
               ch_idx_d  = '0;
               pix_cnt_d = '0;
               if (num_pix != '0) state_d = RUN;
               else               zero_done_d = 1'b1;
            end
         end
         RUN: begin
            if (accept) begin
               if (ch_idx_q == CH_W'(NUM_CH - 1)) begin
                  ch_idx_d  = '0;
                  pix_cnt_d = pix_cnt_q + PIX_W'(1);
               end else begin
                  ch_idx_d  = ch_idx_q + CH_W'(1);
               end
               if (last_beat) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pipe_empty) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ch_idx_q    <= '0;
         pix_cnt_q   <= '0;
         num_pix_q   <= '0;
         zero_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_idx_q    <= ch_idx_d;
         pix_cnt_q   <= pix_cnt_d;
         num_pix_q   <= num_pix_d;
         zero_done_q <= zero_done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = zero_done_q || (state_q == DRAIN && pipe_empty);

   requant_core #(
      .CH_W  (CH_W),
      .SHIFT (SHIFT)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance),
      .in_vld    (accept),
      .in_acc    (in_acc),
      .in_scale  (scale_q[ch_idx_q]),
      .in_ch     (ch_idx_q),
      .in_last   (last_beat),
      .vld_p1    (core_vld_p1),
      .out_valid (out_valid),
      .out_beat  (core_beat),
      .out_sat   (core_sat)
   );

   assign out_q    = core_beat.q;
   assign out_ch   = core_beat.ch[CH_W-1:0];
   assign out_last = core_beat.last;
   // Upper channel bits of the beat (and the sat flag in the default build) go nowhere.
   assign unused_ok = ^{core_beat, core_sat};

`ifdef REQUANT_SATCNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   // Saturation counter: cleared on start, counts clamped beats leaving the pipe.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (state_q == IDLE && start)
         sat_cnt_d = '0;
      else if (out_valid && out_ready && core_sat && sat_cnt_q != 16'hFFFF)
         sat_cnt_d = sat_cnt_q + 16'd1;
   end

   // Saturation counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) sat_cnt_q <= '0;
      else        sat_cnt_q <= sat_cnt_d;
   end

   assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_requant_ctrl.sv
// Scoreboard bench for requant_ctrl with a randomized stimulus driver and an
// independent output monitor. Define REQUANT_SATCNT_EN to cover sat_cnt.
module tb_requant_ctrl;

   localparam int NUM_CH = 16;
   localparam int SHIFT  = 16;
   localparam int PIX_W  = 16;
   localparam int CH_W   = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cfg_we;
   logic [CH_W-1:0]     cfg_addr;
   logic signed [31:0]  cfg_scale;
   logic                start;
   logic [PIX_W-1:0]    num_pix;
   logic                busy, done;
   logic                in_valid, in_ready;
   logic signed [31:0]  in_acc;
   logic                out_valid, out_ready;
   logic signed [7:0]   out_q;
   logic [CH_W-1:0]     out_ch;
   logic                out_last;
`ifdef REQUANT_SATCNT_EN
   logic [15:0]         sat_cnt;
`endif

   requant_ctrl #(.NUM_CH(NUM_CH), .SHIFT(SHIFT), .PIX_W(PIX_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale),
      .start(start), .num_pix(num_pix), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
      .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_ch(out_ch),
      .out_last(out_last)
`ifdef REQUANT_SATCNT_EN
      , .sat_cnt(sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      longint q;
      longint ch;
      longint last;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_cyc = -1;
   int   done_cyc = -1;
   bit   done_seen = 0;
   int   ready_mode = 0;
   int   tbl[NUM_CH];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: exact product, half-away-from-zero division by 2^SHIFT, clamp to int8.
   function automatic longint ref_q(input int acc, input int sc, output bit sat);
      longint p, m, r, v;
      p   = longint'(acc) * longint'(sc);
      m   = (p < 0) ? -p : p;
      r   = (m + (longint'(1) << (SHIFT - 1))) / (longint'(1) << SHIFT);
      v   = (p < 0) ? -r : r;
      sat = (v > 127) || (v < -128);
      if (v > 127)       v = 127;
      else if (v < -128) v = -128;
      return v;
   endfunction

   function automatic int gen_acc(input int pat, input int i);
      case (pat)
         0: return (i % 2 == 0) ? 5 : -7;
         1: case (i % 4)
               0: return 3;
               1: return -3;
               2: return 300;
               default: return -300;
            endcase
         3: return (i < 3) ? 1000 : int'($urandom_range(200)) - 100;
         default: case ($urandom_range(2))
               0: return int'($urandom_range(2000)) - 1000;
               1: return int'($urandom_range(400000)) - 200000;
               default: return int'($urandom());
            endcase
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: always, random, or held off.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every downstream handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got q=%0d ch=%0d with empty scoreboard", out_q, out_ch);
               end else begin
                  mon_e = sb.pop_front();
                  chk("out_q", longint'(out_q), mon_e.q);
                  chk("out_ch", longint'(out_ch), mon_e.ch);
                  chk("out_last", longint'(out_last), mon_e.last);
               end
               if (out_last) last_cyc = cyc;
            end
            if (out_valid && !out_ready) chk("stall_in_ready", longint'(in_ready), 0);
            if (done) begin
               done_seen = 1;
               done_cyc  = cyc;
            end
         end
      end
   end

   task automatic cfg_write(input int a, input int v);
      cfg_we    = 1'b1;
      cfg_addr  = CH_W'(a);
      cfg_scale = v;
      tbl[a]    = v;
      @(posedge clk); #1;
      cfg_we    = 1'b0;
   endtask

   task automatic fill_table(input int mode);
      for (int c = 0; c < NUM_CH; c++) begin
         case (mode)
            0: cfg_write(c, 65536);
            1: cfg_write(c, 32768);
            default: case ($urandom_range(2))
                  0: cfg_write(c, 65536);
                  1: cfg_write(c, int'($urandom_range(262143)) - 131072);
                  default: cfg_write(c, int'($urandom()));
               endcase
         endcase
      end
   endtask

   task automatic send_frame(input int npix, input int pat, input bit poke);
      int   total;
      int   tmo;
      int   exp_sat;
      bit   s;
      exp_t e;
      total     = npix * NUM_CH;
      exp_sat   = 0;
      done_seen = 0;
      start     = 1'b1;
      num_pix   = PIX_W'(npix);
      @(posedge clk); #1;
      start     = 1'b0;
`ifdef REQUANT_SATCNT_EN
      chk("sat_cnt_cleared", longint'(sat_cnt), 0);
`endif
      for (int i = 0; i < total; i++) begin
         if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_acc   = gen_acc(pat, i);
         if (poke && i == 5) begin
            cfg_we    = 1'b1;
            cfg_addr  = CH_W'(6);
            cfg_scale = ~tbl[6];
            start     = 1'b1;
            num_pix   = PIX_W'(1);
         end
         tmo = 0;
         @(negedge clk);
         while (!in_ready && tmo < 2000) begin
            tmo++;
            @(negedge clk);
         end
         if (tmo >= 2000) begin
            $display("FAIL in_ready_timeout: got no in_ready in %0d cycles, expected acceptance", tmo);
            $fatal(1, "in_ready timeout");
         end
         e.q     = ref_q(in_acc, tbl[i % NUM_CH], s);
         e.ch    = i % NUM_CH;
         e.last  = (i == total - 1) ? 1 : 0;
         exp_sat += int'(s);
         sb.push_back(e);
         @(posedge clk); #1;
         cfg_we = 1'b0;
         start  = 1'b0;
      end
      in_valid = 1'b0;
      tmo = 0;
      while (!done_seen && tmo < 2000) begin
         @(posedge clk);
         tmo++;
      end
      chk("done_seen", longint'(done_seen), 1);
      chk("done_latency", longint'(done_cyc - last_cyc), 1);
      @(negedge clk);
      chk("busy_after_done", longint'(busy), 0);
      chk("done_one_cycle", longint'(done), 0);
      chk("sb_drained", longint'(sb.size()), 0);
`ifdef REQUANT_SATCNT_EN
      chk("sat_cnt", longint'(sat_cnt), longint'((exp_sat > 65535) ? 65535 : exp_sat));
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_scale = '0;
      start     = 1'b0;
      num_pix   = '0;
      in_valid  = 1'b0;
      in_acc    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_last", longint'(out_last), 0);
      chk("rst_out_q", longint'(out_q), 0);
      chk("rst_out_ch", longint'(out_ch), 0);
`ifdef REQUANT_SATCNT_EN
      chk("rst_sat_cnt", longint'(sat_cnt), 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Identity scale.
      fill_table(0);
      send_frame(1, 0, 0);
      // Half scale: rounding and clamping.
      fill_table(1);
      send_frame(1, 1, 0);
      // Two-pixel frame with random scales.
      fill_table(2);
      send_frame(2, 2, 0);
      // Random backpressure, with table write and start poked mid-frame.
      ready_mode = 1;
      fill_table(2);
      send_frame(3, 2, 1);
      send_frame(2, 2, 0);
      ready_mode = 0;

      // Zero-pixel frame: done next cycle, nothing emitted.
      start   = 1'b1;
      num_pix = '0;
      @(posedge clk); #1;
      start   = 1'b0;
      @(negedge clk);
      chk("zero_pix_done", longint'(done), 1);
      chk("zero_pix_busy", longint'(busy), 0);
      @(negedge clk);
      chk("zero_pix_done_clear", longint'(done), 0);
      chk("zero_pix_no_output", longint'(out_valid), 0);
      @(posedge clk); #1;

      // Reset in the middle of a stalled frame.
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      start    = 1'b1;
      num_pix  = PIX_W'(3);
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_acc   = 32'sd1;
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      chk("stalled_full_valid", longint'(out_valid), 1);
      chk("stalled_busy", longint'(busy), 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", longint'(out_valid), 0);
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_in_ready", longint'(in_ready), 0);
      in_valid = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      rst_n      = 1'b1;
      ready_mode = 0;
      @(posedge clk); #1;

      // Recovery with three clamped beats, then a clean frame.
      fill_table(0);
      send_frame(1, 3, 0);
      send_frame(1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
